// File: rtl/verificador_pkg.sv
// Shared types and constants for the move checker: FSM states, default sizes
// and the one-hot test used to qualify a published target.
package verificador_pkg;

   localparam int N_BOTOES_DEF      = 4;
   localparam int JANELA_CICLOS_DEF = 50000000;

   typedef enum logic [2:0] {
      OCIOSO,
      AGUARDA_ALVO,
      JANELA,
      ACERTO,
      ERRO,
      SOLTURA
   } estado_t;

   // True only when exactly one bit is set.
   function automatic logic eh_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector across the button bus. The history register resets to
// all ones so a button held through reset is never reported as a press.
module detector_borda #(
   parameter int N_BOTOES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] press
);

   logic [N_BOTOES-1:0] botoes_ant_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         botoes_ant_q <= '1;
      end else begin
         botoes_ant_q <= botoes;
      end
   end

   assign press = botoes & ~botoes_ant_q;

endmodule

// File: rtl/verificador_jogada.sv
// Judges each player move against the latched target and emits one verdict
// pulse (acertou or errou) per target, then waits for all buttons released.
//
// state        | meaning
// -------------+---------------------------------------------------------
// OCIOSO       | game not running, no target held
// AGUARDA_ALVO | waiting for a valid one-hot target strobe
// JANELA       | response window open, timer counting down
// ACERTO       | one-cycle hit pulse
// ERRO         | one-cycle miss pulse (wrong/multiple button or timeout)
// SOLTURA      | target cleared, waiting for all buttons released
module verificador_jogada
   import verificador_pkg::*;
#(
   parameter int N_BOTOES      = N_BOTOES_DEF,
   parameter int JANELA_CICLOS = JANELA_CICLOS_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ativo,
   input  logic                alvo_valido,
   input  logic [N_BOTOES-1:0] alvo,
   input  logic [N_BOTOES-1:0] botoes,
   output logic                acertou,
   output logic                errou,
   output logic                janela_aberta,
   output logic [N_BOTOES-1:0] alvo_atual
);

   localparam int TW = $clog2(JANELA_CICLOS);
   localparam logic [TW-1:0] TIMER_CARGA = TW'(JANELA_CICLOS - 1);

   estado_t             estado_q, estado_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [N_BOTOES-1:0] alvo_q, alvo_d;
   logic [N_BOTOES-1:0] press;

   detector_borda #(
      .N_BOTOES(N_BOTOES)
   ) u_detector_borda (
      .clk   (clk),
      .reset (reset),
      .botoes(botoes),
      .press (press)
   );

   always_comb begin
      estado_d = estado_q;
      timer_d  = timer_q;
      alvo_d   = alvo_q;

      case (estado_q)
         OCIOSO: begin
            if (ativo) estado_d = AGUARDA_ALVO;
         end
         AGUARDA_ALVO: begin
            if (alvo_valido && eh_one_hot(32'(alvo))) begin
               alvo_d   = alvo;
               timer_d  = TIMER_CARGA;
               estado_d = JANELA;
            end
         end
         JANELA: begin
            // alvo_q is one-hot, so an empty press never matches it.
            if (press == alvo_q) begin
               estado_d = ACERTO;
            end else if (press != '0) begin
               estado_d = ERRO;
            end else if (timer_q == '0) begin
               estado_d = ERRO;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ACERTO, ERRO: begin
            estado_d = ativo ? SOLTURA : OCIOSO;
         end
         SOLTURA: begin
            if (botoes == '0) estado_d = AGUARDA_ALVO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase

      // A verdict pulse already under way is allowed to finish.
      if (!ativo && (estado_q != ACERTO) && (estado_q != ERRO)) begin
         estado_d = OCIOSO;
      end

      if ((estado_d == SOLTURA) || (estado_d == OCIOSO)) begin
         alvo_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= OCIOSO;
         timer_q  <= '0;
         alvo_q   <= '0;
      end else begin
         estado_q <= estado_d;
         timer_q  <= timer_d;
         alvo_q   <= alvo_d;
      end
   end

   assign acertou       = (estado_q == ACERTO);
   assign errou         = (estado_q == ERRO);
   assign janela_aberta = (estado_q == JANELA);
   assign alvo_atual    = alvo_q;

endmodule

// File: tb/tb_verificador_jogada.sv
// Directed and randomized bench for verificador_jogada with an 8-cycle window;
// expected verdicts are derived per target from press timing and pattern.
module tb_verificador_jogada;

   localparam int NB  = 4;
   localparam int JAN = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          ativo;
   logic          alvo_valido;
   logic [NB-1:0] alvo;
   logic [NB-1:0] botoes;
   logic          acertou;
   logic          errou;
   logic          janela_aberta;
   logic [NB-1:0] alvo_atual;

   int errors = 0;
   int checks = 0;

   verificador_jogada #(
      .N_BOTOES     (NB),
      .JANELA_CICLOS(JAN)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ativo        (ativo),
      .alvo_valido  (alvo_valido),
      .alvo         (alvo),
      .botoes       (botoes),
      .acertou      (acertou),
      .errou        (errou),
      .janela_aberta(janela_aberta),
      .alvo_atual   (alvo_atual)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic ac, input logic er,
                           input logic ja, input logic [NB-1:0] aa);
      chk({tag, ".acertou"}, 32'(acertou), 32'(ac));
      chk({tag, ".errou"}, 32'(errou), 32'(er));
      chk({tag, ".janela"}, 32'(janela_aberta), 32'(ja));
      chk({tag, ".alvo_atual"}, 32'(alvo_atual), 32'(aa));
   endtask

   // Called with the DUT waiting for a target. k is the window cycle (1..JAN)
   // at which botoes changes to pat (0 = never); pre is held from the strobe.
   task automatic run_trial(input string tag, input logic [NB-1:0] tgt, input int k,
                            input logic [NB-1:0] pat, input logic [NB-1:0] pre,
                            input int hold);
      logic [NB-1:0] pr;
      int            v;
      logic          hit;
      pr  = (k > 0) ? (pat & ~pre) : '0;
      if (pr != '0) begin
         v   = k + 1;
         hit = (pr == tgt);
      end else begin
         v   = JAN + 1;
         hit = 1'b0;
      end

      alvo        = tgt;
      alvo_valido = 1'b1;
      botoes      = pre;
      tick();
      for (int c = 1; c <= v; c++) begin
         chk_outs(tag, (c == v) && hit, (c == v) && !hit, c < v, tgt);
         if (c == k) botoes = pat;
         alvo_valido = (c < v) ? 1'($urandom_range(0, 1)) : 1'b0;
         alvo        = NB'(1 << $urandom_range(0, NB - 1));
         if (c < v) tick();
      end
      alvo_valido = 1'b0;
      tick();
      chk_outs({tag, ".soltura"}, 1'b0, 1'b0, 1'b0, '0);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk_outs({tag, ".hold"}, 1'b0, 1'b0, 1'b0, '0);
      end
      botoes = '0;
      tick();
   endtask

   initial begin
      reset       = 1'b1;
      ativo       = 1'b0;
      alvo_valido = 1'b0;
      alvo        = '0;
      botoes      = '0;
      tick();
      tick();
      chk_outs("reset", 1'b0, 1'b0, 1'b0, '0);

      reset = 1'b0;
      tick();
      chk_outs("ocioso", 1'b0, 1'b0, 1'b0, '0);
      ativo = 1'b1;
      tick();

      run_trial("hit_t3", 4'b0010, 3, 4'b0010, 4'b0000, 1);
      run_trial("wrong_t2", 4'b0100, 2, 4'b0001, 4'b0000, 2);
      run_trial("next_after_release", 4'b0001, 5, 4'b0001, 4'b0000, 0);
      run_trial("timeout", 4'b1000, 0, 4'b0000, 4'b0000, 0);
      run_trial("hit_last_cycle", 4'b1000, JAN, 4'b1000, 4'b0000, 1);
      run_trial("double_press", 4'b0010, 4, 4'b0011, 4'b0000, 1);
      run_trial("held_before", 4'b0010, 0, 4'b0000, 4'b0010, 3);

      alvo        = 4'b0110;
      alvo_valido = 1'b1;
      tick();
      alvo_valido = 1'b0;
      chk_outs("multi_hot_ignored", 1'b0, 1'b0, 1'b0, '0);
      alvo        = 4'b0000;
      alvo_valido = 1'b1;
      tick();
      alvo_valido = 1'b0;
      chk_outs("zero_alvo_ignored", 1'b0, 1'b0, 1'b0, '0);
      tick();
      chk_outs("still_idle", 1'b0, 1'b0, 1'b0, '0);
      run_trial("after_invalid", 4'b0100, 1, 4'b0100, 4'b0000, 0);

      alvo        = 4'b0001;
      alvo_valido = 1'b1;
      tick();
      alvo_valido = 1'b0;
      chk_outs("abort.open", 1'b0, 1'b0, 1'b1, 4'b0001);
      tick();
      tick();
      ativo = 1'b0;
      tick();
      chk_outs("abort.ocioso", 1'b0, 1'b0, 1'b0, '0);
      botoes = 4'b0001;
      tick();
      chk_outs("abort.no_verdict", 1'b0, 1'b0, 1'b0, '0);
      tick();
      chk_outs("abort.no_verdict2", 1'b0, 1'b0, 1'b0, '0);
      botoes = '0;
      ativo  = 1'b1;
      tick();
      run_trial("after_abort", 4'b0001, 2, 4'b0001, 4'b0000, 0);

      alvo        = 4'b0100;
      alvo_valido = 1'b1;
      tick();
      alvo_valido = 1'b0;
      botoes      = 4'b0100;
      tick();
      chk_outs("rst_on_hit.pulse", 1'b1, 1'b0, 1'b0, 4'b0100);
      reset = 1'b1;
      tick();
      chk_outs("rst_on_hit.after", 1'b0, 1'b0, 1'b0, '0);
      reset = 1'b0;
      tick();
      run_trial("held_through_reset", 4'b0100, 0, 4'b0000, 4'b0100, 1);

      for (int i = 0; i < 40; i++) begin
         logic [NB-1:0] t;
         logic [NB-1:0] p;
         int            kk;
         t  = NB'(1 << $urandom_range(0, NB - 1));
         kk = $urandom_range(0, JAN);
         p  = ($urandom_range(0, 1) == 1) ? t : NB'($urandom_range(1, 15));
         run_trial("rand", t, kk, p, 4'b0000, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
